// File: rtl/jstk_cmd_ctrl_if.sv
// Joystick command bundle between a poll controller and its user.
//   en, led, DOUT          : enable, LED request, raw 40-bit joystick frame
//   sndRec, DIN            : transfer request and command byte to the SPI joystick block
//   x_pos, y_pos, btn, dir : latched frame fields and derived drive command
//   valid                  : one-cycle strobe when a new frame has been latched
// The slave modport is the controller; the master modport is the environment.
interface jstk_cmd_ctrl_if;
  logic        en;
  logic [1:0]  led;
  logic [39:0] DOUT;
  logic        sndRec;
  logic [7:0]  DIN;
  logic [9:0]  x_pos;
  logic [9:0]  y_pos;
  logic [2:0]  btn;
  logic [2:0]  dir;
  logic        valid;

  modport master (
    output en, led, DOUT,
    input  sndRec, DIN, x_pos, y_pos, btn, dir, valid
  );

  modport slave (
    input  en, led, DOUT,
    output sndRec, DIN, x_pos, y_pos, btn, dir, valid
  );
endinterface

// File: rtl/jstk_cmd_ctrl.sv
// Periodic joystick poller. Every POLL_CYCLES it raises sndRec for HOLD_CYCLES,
// waits XFER_CYCLES for the SPI transfer, then latches the returned frame,
// decodes X/Y/buttons, derives a drive direction and strobes valid.
//   CLK, RST : clock and synchronous active-high reset
//   js       : jstk_cmd_ctrl_if.slave (en, led, DOUT in; sndRec, DIN,
//              x_pos, y_pos, btn, dir, valid out)
module jstk_cmd_ctrl #(
  parameter int POLL_CYCLES = 1000000,
  parameter int HOLD_CYCLES = 3000,
  parameter int XFER_CYCLES = 100000,
  parameter int DEADZONE    = 64
) (
  input  logic           CLK,
  input  logic           RST,
  jstk_cmd_ctrl_if.slave js
);

  localparam int SEQ_LEN = HOLD_CYCLES + XFER_CYCLES + 2;
  localparam int CNT_MAX = (POLL_CYCLES > SEQ_LEN) ? POLL_CYCLES : SEQ_LEN;
  localparam int CW      = ($clog2(CNT_MAX + 1) > 20) ? $clog2(CNT_MAX + 1) : 20;

  // Counter value on the last cycle of each phase (counter is 0 on TRIG entry).
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(HOLD_CYCLES + XFER_CYCLES - 1);
  localparam logic [CW-1:0] POLL_LAST = CW'(POLL_CYCLES - 1);

  localparam logic [10:0] BAND_HI = 11'(512 + DEADZONE);
  localparam logic [10:0] BAND_LO = 11'(512 - DEADZONE);

  localparam logic [2:0] DIR_STOP  = 3'd0;
  localparam logic [2:0] DIR_FWD   = 3'd1;
  localparam logic [2:0] DIR_BACK  = 3'd2;
  localparam logic [2:0] DIR_LEFT  = 3'd3;
  localparam logic [2:0] DIR_RIGHT = 3'd4;

  typedef enum logic [1:0] {IDLE, TRIG, WAIT, CAPT} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            due;
  logic            snd_rec_r;
  logic [7:0]      din_r;
  logic [9:0]      x_r;
  logic [9:0]      y_r;
  logic [2:0]      btn_r;
  logic [2:0]      dir_r;
  logic            valid_r;

  logic [9:0]      x_cap;
  logic [9:0]      y_cap;
  logic [2:0]      btn_cap;
  logic [2:0]      dir_cap;
  logic            dout_unused;

  // Y outranks X; a value sitting exactly on a band edge is neutral.
  function automatic logic [2:0] dir_of(input logic [9:0] x, input logic [9:0] y);
    logic [10:0] xe;
    logic [10:0] ye;
    xe = {1'b0, x};
    ye = {1'b0, y};
    if (ye > BAND_HI)      return DIR_FWD;
    else if (ye < BAND_LO) return DIR_BACK;
    else if (xe < BAND_LO) return DIR_LEFT;
    else if (xe > BAND_HI) return DIR_RIGHT;
    else                   return DIR_STOP;
  endfunction

  assign x_cap       = {js.DOUT[25:24], js.DOUT[39:32]};
  assign y_cap       = {js.DOUT[9:8],   js.DOUT[23:16]};
  assign btn_cap     = js.DOUT[2:0];
  assign dout_unused = ^{js.DOUT[31:26], js.DOUT[15:10], js.DOUT[7:3]};

  // Stick button is an emergency stop; a disabled capture also yields STOP.
  always_comb begin
    dir_cap = dir_of(x_cap, y_cap);
    if (btn_cap[0] || !js.en) dir_cap = DIR_STOP;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      due       <= 1'b1;
      snd_rec_r <= 1'b0;
      din_r     <= 8'h80;
      x_r       <= 10'd512;
      y_r       <= 10'd512;
      btn_r     <= 3'd0;
      dir_r     <= DIR_STOP;
      valid_r   <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      // Saturate so a long disabled stretch cannot wrap into a false "poll due".
      if (cnt != '1) cnt <= cnt + 1'b1;
      case (state)
        IDLE: begin
          if (!js.en) begin
            // Once disabled, the next enable starts a poll immediately.
            due   <= 1'b1;
            dir_r <= DIR_STOP;
          end else if (due || cnt >= POLL_LAST) begin
            state     <= TRIG;
            cnt       <= '0;
            due       <= 1'b0;
            din_r     <= {6'b100000, js.led};
            snd_rec_r <= 1'b1;
          end
        end
        TRIG: begin
          if (cnt == HOLD_LAST) begin
            state     <= WAIT;
            snd_rec_r <= 1'b0;
          end
        end
        WAIT: begin
          // Capture on entry to CAPT so valid and the new fields appear together.
          if (cnt == WAIT_LAST) begin
            state   <= CAPT;
            x_r     <= x_cap;
            y_r     <= y_cap;
            btn_r   <= btn_cap;
            dir_r   <= dir_cap;
            valid_r <= 1'b1;
          end
        end
        CAPT: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign js.sndRec = snd_rec_r;
  assign js.DIN    = din_r;
  assign js.x_pos  = x_r;
  assign js.y_pos  = y_r;
  assign js.btn    = btn_r;
  assign js.dir    = dir_r;
  assign js.valid  = valid_r;

endmodule
